// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU / programming-controller memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PRG = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; index 0 = CPU, 1 = programming.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       take,
  output logic [1:0] gnt
);
  logic       last;
  logic [1:0] elig;

  assign elig = req & mask;

  // Contested: favour whichever side did not win last time.
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) gnt = (last == OWNER_PRG) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last <= OWNER_PRG;
    else if (take && |gnt)  last <= gnt[1];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between a CPU and a programming
// controller; one transaction per IDLE -> CMD -> RESP pass.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  input  logic                      cpu_req_we,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [MEM_DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                      cpu_req_ready,
  output logic                      cpu_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] cpu_rsp_rdata,
  input  logic                      prg_req_valid,
  input  logic                      prg_req_we,
  input  logic [MEM_ADDR_WIDTH-1:0] prg_req_addr,
  input  logic [MEM_DATA_WIDTH-1:0] prg_req_wdata,
  output logic                      prg_req_ready,
  output logic                      prg_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] prg_rsp_rdata,
  input  logic                      prg_lock,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic                      owner,
  output logic                      busy
);
  arb_state_e                state;
  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_DATA_WIDTH-1:0] r_wdata;
  logic [1:0]                gnt;
  logic                      take;
  logic                      in_resp;

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign take = (state == ST_IDLE) && !rst;

  rr_arbiter2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  ({prg_req_valid, cpu_req_valid}),
    .mask ({1'b1, ~prg_lock}),
    .take (take),
    .gnt  (gnt)
  );

  assign cpu_req_ready = take && gnt[0];
  assign prg_req_ready = take && gnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      owner   <= OWNER_CPU;
    end else begin
      case (state)
        ST_IDLE: if (|gnt) begin
          r_we    <= gnt[1] ? prg_req_we    : cpu_req_we;
          r_addr  <= gnt[1] ? prg_req_addr  : cpu_req_addr;
          r_wdata <= gnt[1] ? prg_req_wdata : cpu_req_wdata;
          owner   <= gnt[1];
          state   <= ST_CMD;
        end
        ST_CMD:  state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign mem_en    = (state == ST_CMD);
  assign mem_we    = (state == ST_CMD) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign in_resp       = (state == ST_RESP);
  assign cpu_rsp_valid = in_resp && (owner == OWNER_CPU);
  assign prg_rsp_valid = in_resp && (owner == OWNER_PRG);
  assign cpu_rsp_rdata = (cpu_rsp_valid && !r_we) ? mem_rdata : '0;
  assign prg_rsp_rdata = (prg_rsp_valid && !r_we) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_valid = 0, cpu_req_we = 0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_req_ready, cpu_rsp_valid;
  logic [DW-1:0] cpu_rsp_rdata;
  logic          prg_req_valid = 0, prg_req_we = 0;
  logic [AW-1:0] prg_req_addr = '0;
  logic [DW-1:0] prg_req_wdata = '0;
  logic          prg_req_ready, prg_rsp_valid;
  logic [DW-1:0] prg_rsp_rdata;
  logic          prg_lock = 0;
  logic          mem_en, mem_we, owner, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;
  int prg_rsps;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  mem_port_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .prg_req_valid(prg_req_valid), .prg_req_we(prg_req_we),
    .prg_req_addr(prg_req_addr), .prg_req_wdata(prg_req_wdata),
    .prg_req_ready(prg_req_ready), .prg_rsp_valid(prg_rsp_valid),
    .prg_rsp_rdata(prg_rsp_rdata),
    .prg_lock(prg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full single-requester transaction; entered and left 1ns after an IDLE edge.
  task automatic txn(input logic prg, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
    if (prg) begin prg_req_valid = 1; prg_req_we = we; prg_req_addr = a; prg_req_wdata = wd; end
    else     begin cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd; end
    #1;
    chk("txn_ready", {cpu_req_ready, prg_req_ready}, prg ? 2'b01 : 2'b10);
    chk("txn_idle_busy", busy, 0);
    tick();
    cpu_req_valid = 0; prg_req_valid = 0;
    cpu_req_addr = '0; prg_req_addr = '0; cpu_req_wdata = '0; prg_req_wdata = '0;
    chk("txn_cmd", {mem_en, mem_we, busy, owner}, {1'b1, we, 1'b1, prg});
    chk("txn_addr", mem_addr, a);
    if (we) chk("txn_wdata", mem_wdata, wd);
    tick();
    chk("txn_rspv", {cpu_rsp_valid, prg_rsp_valid}, prg ? 2'b01 : 2'b10);
    chk("txn_rdata", prg ? prg_rsp_rdata : cpu_rsp_rdata, we ? '0 : rd_exp);
    chk("txn_other_rdata", prg ? cpu_rsp_rdata : prg_rsp_rdata, 0);
    chk("txn_resp_mem_en", mem_en, 0);
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_outs", {cpu_req_ready, cpu_rsp_valid, prg_req_ready, prg_rsp_valid,
                     mem_en, mem_we, owner, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 0;
    tick();

    // Contested grant right after reset: CPU, then programming.
    cpu_req_valid = 1; cpu_req_addr = 10'h005;
    prg_req_valid = 1; prg_req_addr = 10'h006;
    #1;
    chk("rr_first_cpu", {cpu_req_ready, prg_req_ready}, 2'b10);
    tick();
    chk("rr_owner0", owner, 0);
    chk("rr_addr0", mem_addr, 10'h005);
    tick(); tick();
    #1;
    chk("rr_second_prg", {cpu_req_ready, prg_req_ready}, 2'b01);
    tick();
    cpu_req_valid = 0; prg_req_valid = 0;
    chk("rr_owner1", owner, 1);
    chk("rr_addr1", mem_addr, 10'h006);
    tick(); tick();

    // Write then read back the same address.
    txn(0, 1, 10'h005, 32'hDEADBEEF, '0);
    txn(0, 0, 10'h005, '0, 32'hDEADBEEF);
    txn(0, 1, 10'h000, 32'h0000A5A5, '0);

    // Lock: four programming reads while the CPU waits.
    prg_lock = 1;
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h000;
    prg_req_valid = 1; prg_req_we = 0; prg_req_addr = 10'h005;
    prg_rsps = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lock_ready", {cpu_req_ready, prg_req_ready}, 2'b01);
      tick(); tick();
      if (prg_rsp_valid && prg_rsp_rdata == 32'hDEADBEEF) prg_rsps++;
      if (i == 3) begin prg_lock = 0; prg_req_valid = 0; end
      tick();
    end
    chk("lock_rsp_count", prg_rsps, 4);
    #1;
    chk("unlock_cpu_grant", {cpu_req_ready, prg_req_ready}, 2'b10);
    tick();
    cpu_req_valid = 0;
    tick();
    chk("unlock_cpu_rsp", {cpu_rsp_valid, cpu_rsp_rdata}, {1'b1, 32'h0000A5A5});
    tick();

    // Lock raised mid-flight of a CPU read of the top address.
    txn(1, 1, 10'h3FF, 32'h12345678, '0);
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h3FF;
    tick();
    cpu_req_valid = 1; prg_req_valid = 1; prg_req_we = 0; prg_req_addr = 10'h005;
    prg_lock = 1;
    chk("midlock_cmd_owner", owner, 0);
    tick();
    chk("midlock_cpu_rsp", {cpu_rsp_valid, cpu_rsp_rdata}, {1'b1, 32'h12345678});
    tick();
    #1;
    chk("midlock_next_prg", {cpu_req_ready, prg_req_ready}, 2'b01);
    tick();
    cpu_req_valid = 0; prg_req_valid = 0; prg_lock = 0;
    tick(); tick();

    // Reset during CMD of a programming write aborts it.
    prg_req_valid = 1; prg_req_we = 1; prg_req_addr = 10'h000; prg_req_wdata = 32'h00000BAD;
    tick();
    prg_req_valid = 0;
    chk("abort_in_cmd", mem_en, 1);
    rst = 1;
    #1;
    chk("abort_outs", {cpu_req_ready, cpu_rsp_valid, prg_req_ready, prg_rsp_valid,
                       mem_en, mem_we, owner, busy}, 0);
    chk("abort_rdata", prg_rsp_rdata, 0);
    tick();
    rst = 0;
    chk("abort_no_rsp", prg_rsp_valid, 0);
    tick();
    chk("abort_still_idle", {busy, prg_rsp_valid}, 0);
    txn(0, 0, 10'h000, '0, 32'h0000A5A5);

    // Continuous CPU reads: ready once per 3 cycles, busy 0,1,1.
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h005;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("stream_ready", cpu_req_ready, (i % 3 == 0) ? 1 : 0);
      chk("stream_busy", busy, (i % 3 == 0) ? 0 : 1);
      tick();
    end
    cpu_req_valid = 0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
